// File: rtl/afe_spi_master.sv
// ---------------------------------------------------------------------------
// afe_spi_master
//
// Serial write engine for the AFE attenuator/control ports. A word accepted on
// the wrValid/wrReady handshake is shifted MSB-first to every AFE selected in
// wrSel at the same time, followed by a latch-enable pulse. Each serial clock
// half period, the LE setup time and the LE pulse each last HALF_PERIOD
// sysClk cycles.
//
// Ports:
//   sysClk       system clock (~100 MHz)
//   sysReset_n   synchronous, active-low reset
//   wrValid      write request
//   wrReady      engine idle and able to accept a request
//   wrData       word to shift, MSB first
//   wrSel        bitmask of target AFEs; an all-zero mask consumes the request
//                with no pin activity
//   doneStrobe   one-cycle pulse when a write completes
//   busy         transaction in progress
//   AFE_SPI_CLK  serial clock per AFE
//   AFE_SPI_SDI  serial data per AFE
//   AFE_SPI_LE   latch enable per AFE
//
// All outputs are registered: the combinational process computes the next
// state and decodes the next pin values from it, so every pin comes straight
// from a flop.
// ---------------------------------------------------------------------------
module afe_spi_master #(
    parameter int AFE_COUNT   = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int HALF_PERIOD = 50
) (
    input  logic                  sysClk,
    input  logic                  sysReset_n,
    input  logic                  wrValid,
    output logic                  wrReady,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [AFE_COUNT-1:0]  wrSel,
    output logic                  doneStrobe,
    output logic                  busy,
    output logic [AFE_COUNT-1:0]  AFE_SPI_CLK,
    output logic [AFE_COUNT-1:0]  AFE_SPI_SDI,
    output logic [AFE_COUNT-1:0]  AFE_SPI_LE
);

    // The half-period counter is sized for the largest legal HALF_PERIOD.
    localparam int HP_W  = 10;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_WIDTH - 1);

    generate
        if (HALF_PERIOD < 2 || HALF_PERIOD > 1023) begin : g_bad_half_period
            $fatal(1, "afe_spi_master: HALF_PERIOD must be in 2..1023");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        LE_SETUP,
        LE_HIGH
    } state_t;

    state_t                 state, state_next;
    logic [HP_W-1:0]        hp_cnt, hp_cnt_next;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0]  data_q, data_next;
    logic [AFE_COUNT-1:0]   sel_q, sel_next;

    logic                   accept;
    logic                   ready_next;
    logic                   busy_next;
    logic                   done_next;
    logic [AFE_COUNT-1:0]   clk_next;
    logic [AFE_COUNT-1:0]   sdi_next;
    logic [AFE_COUNT-1:0]   le_next;

    // wrReady is high only in IDLE, so this also qualifies on the state.
    assign accept = wrValid && wrReady && (|wrSel);

    // -----------------------------------------------------------------------
    // Next-state and next-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next   = state;
        hp_cnt_next  = hp_cnt;
        bit_cnt_next = bit_cnt;
        data_next    = data_q;
        sel_next     = sel_q;
        done_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = BIT_LO;
                    hp_cnt_next  = HP_LOAD;
                    bit_cnt_next = BIT_LOAD;
                    data_next    = wrData;
                    sel_next     = wrSel;
                end
            end

            BIT_LO: begin
                if (hp_cnt == '0) begin
                    state_next  = BIT_HI;
                    hp_cnt_next = HP_LOAD;
                end else begin
                    hp_cnt_next = hp_cnt - 1'b1;
                end
            end

            BIT_HI: begin
                if (hp_cnt == '0) begin
                    hp_cnt_next = HP_LOAD;
                    if (bit_cnt == '0) begin
                        state_next = LE_SETUP;
                    end else begin
                        // The next bit appears on SDI in the same cycle CLK falls.
                        state_next   = BIT_LO;
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end else begin
                    hp_cnt_next = hp_cnt - 1'b1;
                end
            end

            LE_SETUP: begin
                if (hp_cnt == '0) begin
                    state_next  = LE_HIGH;
                    hp_cnt_next = HP_LOAD;
                end else begin
                    hp_cnt_next = hp_cnt - 1'b1;
                end
            end

            LE_HIGH: begin
                if (hp_cnt == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    hp_cnt_next = hp_cnt - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Pin values for the state being entered. The bit counter parks at 0
        // after the LSB, so SDI holds the LSB through LE_SETUP and LE_HIGH.
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
        clk_next   = (state_next == BIT_HI)  ? sel_next : '0;
        le_next    = (state_next == LE_HIGH) ? sel_next : '0;
        sdi_next   = (busy_next && data_next[bit_cnt_next]) ? sel_next : '0;
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state       <= IDLE;
            hp_cnt      <= '0;
            bit_cnt     <= '0;
            wrReady     <= 1'b1;
            busy        <= 1'b0;
            doneStrobe  <= 1'b0;
            AFE_SPI_CLK <= '0;
            AFE_SPI_SDI <= '0;
            AFE_SPI_LE  <= '0;
        end else begin
            state       <= state_next;
            hp_cnt      <= hp_cnt_next;
            bit_cnt     <= bit_cnt_next;
            wrReady     <= ready_next;
            busy        <= busy_next;
            doneStrobe  <= done_next;
            AFE_SPI_CLK <= clk_next;
            AFE_SPI_SDI <= sdi_next;
            AFE_SPI_LE  <= le_next;
        end
    end

    // NOTE: the latched word and mask carry no reset; they are only observed
    // through pins that are gated by the state, which is reset.
    always_ff @(posedge sysClk) begin
        data_q <= data_next;
        sel_q  <= sel_next;
    end

endmodule

// File: tb/tb_afe_spi_master.sv
// ---------------------------------------------------------------------------
// tb_afe_spi_master
//
// Directed bench for afe_spi_master with HALF_PERIOD = 4, DATA_WIDTH = 16.
// Inputs change and outputs are sampled on the falling sysClk edge. A single
// sampling task records per-AFE serial clock edges, the SDI word captured on
// rising CLK, CLK high/low run lengths, LE activity, accepts and done pulses.
// ---------------------------------------------------------------------------
module tb_afe_spi_master;

    localparam int AFE_COUNT   = 2;
    localparam int DATA_WIDTH  = 16;
    localparam int HALF_PERIOD = 4;
    localparam int XFER_CYC    = (2 * DATA_WIDTH + 2) * HALF_PERIOD;  // 136

    logic                  sysClk;
    logic                  sysReset_n;
    logic                  wrValid;
    logic                  wrReady;
    logic [DATA_WIDTH-1:0] wrData;
    logic [AFE_COUNT-1:0]  wrSel;
    logic                  doneStrobe;
    logic                  busy;
    logic [AFE_COUNT-1:0]  AFE_SPI_CLK;
    logic [AFE_COUNT-1:0]  AFE_SPI_SDI;
    logic [AFE_COUNT-1:0]  AFE_SPI_LE;

    afe_spi_master #(
        .AFE_COUNT   (AFE_COUNT),
        .DATA_WIDTH  (DATA_WIDTH),
        .HALF_PERIOD (HALF_PERIOD)
    ) dut (
        .sysClk      (sysClk),
        .sysReset_n  (sysReset_n),
        .wrValid     (wrValid),
        .wrReady     (wrReady),
        .wrData      (wrData),
        .wrSel       (wrSel),
        .doneStrobe  (doneStrobe),
        .busy        (busy),
        .AFE_SPI_CLK (AFE_SPI_CLK),
        .AFE_SPI_SDI (AFE_SPI_SDI),
        .AFE_SPI_LE  (AFE_SPI_LE)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor state
    int          cyc;
    int          edges    [AFE_COUNT];
    logic [31:0] sh       [AFE_COUNT];
    int          lo_run   [AFE_COUNT];
    int          lo_min   [AFE_COUNT];
    int          lo_max   [AFE_COUNT];
    int          gap17    [AFE_COUNT];
    int          hi_run   [AFE_COUNT];
    int          hi_min   [AFE_COUNT];
    int          hi_max   [AFE_COUNT];
    int          le_cyc   [AFE_COUNT];
    int          le_rise  [AFE_COUNT];
    int          act      [AFE_COUNT];
    int          diff_cnt;
    int          overlap_cnt;
    int          done_cnt;
    int          done_first;
    int          done_last;
    int          acc_cnt;
    int          acc_last;
    logic        acc_done_flag;
    int          ready_low;
    int          busy_cyc;
    logic [AFE_COUNT-1:0] prev_clk;
    logic [AFE_COUNT-1:0] prev_le;
    bit          scramble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc           = 0;
        diff_cnt      = 0;
        overlap_cnt   = 0;
        done_cnt      = 0;
        done_first    = 0;
        done_last     = 0;
        acc_cnt       = 0;
        acc_last      = 0;
        acc_done_flag = 1'b0;
        ready_low     = 0;
        busy_cyc      = 0;
        for (int k = 0; k < AFE_COUNT; k++) begin
            edges[k]   = 0;
            sh[k]      = '0;
            lo_run[k]  = 0;
            lo_min[k]  = 1000;
            lo_max[k]  = 0;
            gap17[k]   = 0;
            hi_run[k]  = 0;
            hi_min[k]  = 1000;
            hi_max[k]  = 0;
            le_cyc[k]  = 0;
            le_rise[k] = 0;
            act[k]     = 0;
        end
        prev_clk = AFE_SPI_CLK;
        prev_le  = AFE_SPI_LE;
    endtask

    // Advance one cycle: note whether the coming rising edge accepts, then
    // sample every output on the falling edge.
    task automatic tick();
        logic acc;
        logic dn;
        acc = wrValid && wrReady && (wrSel != '0) && sysReset_n;
        dn  = doneStrobe;
        @(negedge sysClk);
        cyc++;
        if (acc) begin
            acc_cnt++;
            acc_last      = cyc;
            acc_done_flag = dn;
        end
        for (int k = 0; k < AFE_COUNT; k++) begin
            if (AFE_SPI_CLK[k] && !prev_clk[k]) begin
                sh[k] = {sh[k][30:0], AFE_SPI_SDI[k]};
                edges[k]++;
                if (edges[k] >= 2) begin
                    if (lo_run[k] < lo_min[k]) lo_min[k] = lo_run[k];
                    if (lo_run[k] > lo_max[k]) lo_max[k] = lo_run[k];
                end
                if (edges[k] == 17) gap17[k] = lo_run[k];
                lo_run[k] = 0;
            end
            if (!AFE_SPI_CLK[k]) lo_run[k]++;
            if (AFE_SPI_CLK[k]) hi_run[k]++;
            if (!AFE_SPI_CLK[k] && prev_clk[k]) begin
                if (hi_run[k] < hi_min[k]) hi_min[k] = hi_run[k];
                if (hi_run[k] > hi_max[k]) hi_max[k] = hi_run[k];
                hi_run[k] = 0;
            end
            if (AFE_SPI_LE[k]) le_cyc[k]++;
            if (AFE_SPI_LE[k] && !prev_le[k]) le_rise[k]++;
            if (AFE_SPI_CLK[k] || AFE_SPI_SDI[k] || AFE_SPI_LE[k]) act[k]++;
            if (AFE_SPI_LE[k] && AFE_SPI_CLK[k]) overlap_cnt++;
        end
        if ({AFE_SPI_CLK[0], AFE_SPI_SDI[0], AFE_SPI_LE[0]} !=
            {AFE_SPI_CLK[1], AFE_SPI_SDI[1], AFE_SPI_LE[1]}) diff_cnt++;
        if (doneStrobe) begin
            done_cnt++;
            if (done_cnt == 1) done_first = cyc;
            done_last = cyc;
        end
        if (!wrReady) ready_low++;
        if (busy) busy_cyc++;
        prev_clk = AFE_SPI_CLK;
        prev_le  = AFE_SPI_LE;
        if (scramble) begin
            wrData = 16'($urandom);
            wrSel  = 2'($urandom);
        end
    endtask

    task automatic start_write(input logic [15:0] data, input logic [1:0] sel);
        wrData  = data;
        wrSel   = sel;
        wrValid = 1'b1;
        tick();
        wrValid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        check(tag, done_cnt, target);
        repeat (3) tick();
    endtask

    initial begin
        sysReset_n = 1'b0;
        wrValid    = 1'b0;
        wrData     = '0;
        wrSel      = '0;
        scramble   = 1'b0;
        repeat (3) @(negedge sysClk);
        clear_mon();
        tick();

        // Reset state
        check("rst_ready", wrReady, 1);
        check("rst_busy",  busy, 0);
        check("rst_done",  doneStrobe, 0);
        check("rst_pins",  {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
        sysReset_n = 1'b1;
        tick();

        // Single write to AFE0
        clear_mon();
        start_write(16'hA5C3, 2'b01);
        wait_done("t1_done", 1, 300);
        check("t1_accept",  acc_cnt, 1);
        check("t1_word",    sh[0], 32'h0000_A5C3);
        check("t1_edges",   edges[0], 16);
        check("t1_afe1",    act[1], 0);
        check("t1_le",      le_cyc[0], HALF_PERIOD);
        check("t1_latency", done_last - acc_last, XFER_CYC);
        check("t1_busy",    busy_cyc, XFER_CYC);
        check("t1_nready",  ready_low, XFER_CYC);
        check("t1_end",     {wrReady, busy, AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 8'b1000_0000);

        // Both AFEs, all ones
        clear_mon();
        start_write(16'hFFFF, 2'b11);
        wait_done("t2_done", 1, 300);
        check("t2_word0",  sh[0], 32'h0000_FFFF);
        check("t2_word1",  sh[1], 32'h0000_FFFF);
        check("t2_same",   diff_cnt, 0);
        check("t2_edges0", edges[0], 16);
        check("t2_edges1", edges[1], 16);
        check("t2_hi_min", hi_min[0], HALF_PERIOD);
        check("t2_hi_max", hi_max[0], HALF_PERIOD);
        check("t2_lo_min", lo_min[0], HALF_PERIOD);
        check("t2_lo_max", lo_max[0], HALF_PERIOD);
        check("t2_le1",    le_cyc[1], HALF_PERIOD);

        // Back-to-back words with wrValid held high
        clear_mon();
        wrData  = 16'h0001;
        wrSel   = 2'b01;
        wrValid = 1'b1;
        for (int i = 0; i < 400 && acc_cnt < 2; i++) begin
            tick();
            if (acc_cnt == 1) wrData = 16'h8000;
        end
        wrValid = 1'b0;
        check("t3_accepts", acc_cnt, 2);
        check("t3_in_done", acc_done_flag, 1);
        wait_done("t3_done", 2, 300);
        check("t3_words",   sh[0], 32'h0001_8000);
        check("t3_edges",   edges[0], 32);
        check("t3_gap",     gap17[0], 3 * HALF_PERIOD + 1);
        check("t3_le_rise", le_rise[0], 2);
        check("t3_le_cyc",  le_cyc[0], 2 * HALF_PERIOD);
        check("t3_overlap", overlap_cnt, 0);
        check("t3_latency", done_last - acc_last, XFER_CYC);

        // Empty select mask: consumed, no activity
        clear_mon();
        start_write(16'hFFFF, 2'b00);
        check("t4_ready_now", wrReady, 1);
        repeat (10) tick();
        check("t4_accept", acc_cnt, 0);
        check("t4_ready",  ready_low, 0);
        check("t4_busy",   busy_cyc, 0);
        check("t4_pins",   act[0] + act[1], 0);
        check("t4_done",   done_cnt, 0);

        // Reset during bit 7, then a normal write
        clear_mon();
        start_write(16'hABCD, 2'b11);
        for (int i = 0; i < 200 && edges[0] < 9; i++) tick();
        check("t5_reach_bit7", edges[0], 9);
        sysReset_n = 1'b0;
        tick();
        sysReset_n = 1'b1;
        check("t5_pins",  {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
        check("t5_ready", wrReady, 1);
        check("t5_busy",  busy, 0);
        repeat (150) tick();
        check("t5_no_done",  done_cnt, 0);
        check("t5_no_edges", edges[0], 9);
        clear_mon();
        start_write(16'h1234, 2'b01);
        wait_done("t5_done", 1, 300);
        check("t5_word",    sh[0], 32'h0000_1234);
        check("t5_latency", done_last - acc_last, XFER_CYC);

        // Inputs scrambled while busy; latched word must be shifted
        clear_mon();
        start_write(16'h3C5A, 2'b10);
        scramble = 1'b1;
        for (int i = 0; i < 300 && done_cnt < 1; i++) tick();
        scramble = 1'b0;
        wrData   = '0;
        wrSel    = '0;
        check("t6_done",  done_cnt, 1);
        check("t6_word",  sh[1], 32'h0000_3C5A);
        check("t6_edges", edges[1], 16);
        check("t6_afe0",  act[0], 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
